matrix_scan_ctrl: RTL and testbench

//  Scan sequencer for the HUB75-style RGB matrix panel. Fetches pixel words from a

---
 rtl/matrix_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// HUB75 scan sequencer: framebuffer fetch, per-row bit-plane shift, latch, binary-weighted OE.
// Optional MATRIX_DBUF_EN adds double-buffer select (swap_req/swap_ack/fb_sel).
module matrix_scan_ctrl #(
  parameter int COL_W   = 5,
  parameter int ROW_W   = 4,
  parameter int BITS    = 4,
  parameter int BASE_OE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
`ifdef MATRIX_DBUF_EN
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   fb_sel,
  output logic [ROW_W+COL_W:0]   fb_addr,
`else
  output logic [ROW_W+COL_W-1:0] fb_addr,
`endif
  output logic                   fb_rd,
  input  logic [6*BITS-1:0]      fb_data,
  output logic [1:0]             mat_r,
  output logic [1:0]             mat_g,
  output logic [1:0]             mat_b,
  output logic [ROW_W-1:0]       mat_row,
  output logic                   mat_clk,
  output logic                   mat_lat,
  output logic                   mat_oe,
  output logic                   frame_start
);

  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH0, LATCH1, DISPLAY, NEXT} state_t;

  state_t           state, state_nx;
  logic [1:0]       phase;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PW-1:0]    plane;
  logic [15:0]      oe_cnt;
  logic             frame_pend;
  logic             last_plane, frame_end;
  logic [BITS-1:0]  r0, g0, b0, r1, g1, b1;

  assign {b1, g1, r1, b0, g0, r0} = fb_data;
  assign last_plane = (plane == PW'(BITS - 1));
  assign frame_end  = last_plane && (row == '1);

`ifdef MATRIX_DBUF_EN
  assign fb_addr = fb_rd ? {fb_sel, row, col} : '0;
`else
  assign fb_addr = fb_rd ? {row, col} : '0;
`endif

  always_comb begin
    state_nx    = state;
    fb_rd       = 1'b0;
    mat_clk     = 1'b0;
    mat_lat     = 1'b0;
    mat_oe      = 1'b1;
    frame_start = 1'b0;
`ifdef MATRIX_DBUF_EN
    swap_ack    = 1'b0;
`endif
    case (state)
      IDLE: if (en) state_nx = SHIFT;
      SHIFT: begin
        fb_rd       = (phase == 2'd0);
        mat_clk     = (phase == 2'd2);
        frame_start = frame_pend && (phase == 2'd0);
        if (phase == 2'd2 && col == '0) state_nx = LATCH0;
      end
      LATCH0: begin
        mat_lat  = 1'b1;
        state_nx = LATCH1;
      end
      LATCH1: state_nx = DISPLAY;
      DISPLAY: begin
        mat_oe = 1'b0;
        if (oe_cnt == 16'd1) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = en ? SHIFT : IDLE;
`ifdef MATRIX_DBUF_EN
        swap_ack = frame_end && swap_req;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= '0;
      col        <= '1;
      row        <= '0;
      plane      <= '0;
      oe_cnt     <= '0;
      frame_pend <= 1'b0;
      mat_r      <= '0;
      mat_g      <= '0;
      mat_b      <= '0;
      mat_row    <= '0;
`ifdef MATRIX_DBUF_EN
      fb_sel     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          row        <= '0;
          plane      <= '0;
          col        <= '1;
          phase      <= '0;
          frame_pend <= 1'b1;
        end
        SHIFT: begin
          frame_pend <= 1'b0;
          if (phase == 2'd1) begin
            mat_r <= {r1[plane], r0[plane]};
            mat_g <= {g1[plane], g0[plane]};
            mat_b <= {b1[plane], b0[plane]};
          end
          // col wraps back to all-ones after column 0, ready for the next plane
          if (phase == 2'd2) begin
            phase <= '0;
            col   <= col - COL_W'(1);
          end else begin
            phase <= phase + 2'd1;
          end
        end
        // mat_row updates on entry to L1 so the new address appears only while blanked
        LATCH0:  mat_row <= row;
        LATCH1:  oe_cnt  <= 16'(BASE_OE) << plane;
        DISPLAY: oe_cnt  <= oe_cnt - 16'd1;
        NEXT: begin
          if (last_plane) begin
            plane <= '0;
            row   <= row + ROW_W'(1);
          end else begin
            plane <= plane + PW'(1);
          end
          if (frame_end) frame_pend <= 1'b1;
          if (!en) begin
            row   <= '0;
            plane <= '0;
          end
`ifdef MATRIX_DBUF_EN
          if (frame_end && swap_req) fb_sel <= ~fb_sel;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl (COL_W=2, ROW_W=1, BITS=2, BASE_OE=2).
// Honours MATRIX_DBUF_EN when defined.
module tb_matrix_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [11:0] fb_word;
  logic [11:0] fb_data;
  logic        fb_rd;
  logic [1:0]  mat_r, mat_g, mat_b;
  logic [0:0]  mat_row;
  logic        mat_clk, mat_lat, mat_oe, frame_start;
`ifdef MATRIX_DBUF_EN
  logic        swap_req, swap_ack, fb_sel;
  logic [3:0]  fb_addr;
`else
  logic [2:0]  fb_addr;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_row_lat;
  logic exp_sel;
  logic rgb_chk;

  localparam logic [11:0] W0  = 12'h00F;
  localparam logic [11:0] W1  = 12'h02A;
  localparam logic [11:0] WF  = 12'hE46;
  localparam logic [5:0]  RA  = 6'b01_01_00;
  localparam logic [5:0]  RB  = 6'b01_01_01;
  localparam logic [5:0]  FP0 = 6'b10_01_10;
  localparam logic [5:0]  FP1 = 6'b01_10_10;

  assign fb_data = fb_word;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.COL_W(2), .ROW_W(1), .BITS(2), .BASE_OE(2)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef MATRIX_DBUF_EN
    .swap_req(swap_req), .swap_ack(swap_ack), .fb_sel(fb_sel),
`endif
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b), .mat_row(mat_row),
    .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe), .frame_start(frame_start)
  );

  typedef struct {
    logic [11:0] word;
    logic [4:0]  ctl;   // {fb_rd, mat_clk, mat_lat, mat_oe, frame_start}
    logic [2:0]  addr;
    logic [5:0]  rgb;   // {mat_r, mat_g, mat_b}
  } vec_t;

  vec_t tbl [36];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ctl"}, 32'({fb_rd, mat_clk, mat_lat, mat_oe, frame_start}), 32'(5'b00010));
    chk({tag, "_row"}, 32'(mat_row), 32'd0);
    chk({tag, "_rgb"}, 32'({mat_r, mat_g, mat_b}), 32'd0);
    chk({tag, "_addr"}, 32'(fb_addr), 32'd0);
`ifdef MATRIX_DBUF_EN
    chk({tag, "_sel"}, 32'({fb_sel, swap_ack}), 32'd0);
`endif
  endtask

  // c = cycles since the frame's first SHIFT cycle; row period 36, planes 17/19
  task automatic check_model(input int c);
    int         o, po, row;
    logic       p1, rd, ck, lt, oe, fs;
    logic [1:0] colx;
    logic [2:0] addr;
    o    = c % 36;
    p1   = (o >= 17);
    po   = p1 ? o - 17 : o;
    row  = (c / 36) % 2;
    rd   = (po < 12) && (po % 3 == 0);
    ck   = (po < 12) && (po % 3 == 2);
    lt   = (po == 12);
    oe   = !((po >= 14) && (po < (p1 ? 18 : 16)));
    fs   = (c % 72 == 0);
    colx = 2'(3 - po / 3);
    addr = rd ? {row[0], colx} : 3'd0;
    if (po == 13) exp_row_lat = row[0];
    chk("ctl", 32'({fb_rd, mat_clk, mat_lat, mat_oe, frame_start}), 32'({rd, ck, lt, oe, fs}));
    chk("fb_addr", 32'(rd ? fb_addr[2:0] : 3'd0), 32'(addr));
    chk("mat_row", 32'(mat_row), 32'(exp_row_lat));
    if (mat_lat || mat_clk) chk("oe_blank", 32'(mat_oe), 32'd1);
    if (ck && rgb_chk) chk("rgb", 32'({mat_r, mat_g, mat_b}), 32'(p1 ? FP1 : FP0));
`ifdef MATRIX_DBUF_EN
    begin
      logic ack;
      ack = swap_req && (c % 72 == 71);
      chk("swap_ack", 32'(swap_ack), 32'(ack));
      chk("fb_sel", 32'(fb_sel), 32'(exp_sel));
      if (rd) chk("addr_msb", 32'(fb_addr[3]), 32'(exp_sel));
      if (ack) exp_sel = ~exp_sel;
    end
`endif
  endtask

  initial begin
    tbl[0]  = '{W0, 5'b10011, 3'd3, 6'b0};
    tbl[1]  = '{W0, 5'b00010, 3'd0, 6'b0};
    tbl[2]  = '{W0, 5'b01010, 3'd0, RA};
    tbl[3]  = '{W0, 5'b10010, 3'd2, RA};
    tbl[4]  = '{W0, 5'b00010, 3'd0, RA};
    tbl[5]  = '{W0, 5'b01010, 3'd0, RA};
    tbl[6]  = '{W0, 5'b10010, 3'd1, RA};
    tbl[7]  = '{W0, 5'b00010, 3'd0, RA};
    tbl[8]  = '{W0, 5'b01010, 3'd0, RA};
    tbl[9]  = '{W0, 5'b10010, 3'd0, RA};
    tbl[10] = '{W0, 5'b00010, 3'd0, RA};
    tbl[11] = '{W0, 5'b01010, 3'd0, RA};
    tbl[12] = '{W0, 5'b00110, 3'd0, RA};
    tbl[13] = '{W0, 5'b00010, 3'd0, RA};
    tbl[14] = '{W0, 5'b00000, 3'd0, RA};
    tbl[15] = '{W0, 5'b00000, 3'd0, RA};
    tbl[16] = '{W0, 5'b00010, 3'd0, RA};
    tbl[17] = '{W1, 5'b10010, 3'd3, RA};
    tbl[18] = '{W1, 5'b00010, 3'd0, RA};
    tbl[19] = '{W1, 5'b01010, 3'd0, RB};
    tbl[20] = '{W1, 5'b10010, 3'd2, RB};
    tbl[21] = '{W1, 5'b00010, 3'd0, RB};
    tbl[22] = '{W1, 5'b01010, 3'd0, RB};
    tbl[23] = '{W1, 5'b10010, 3'd1, RB};
    tbl[24] = '{W1, 5'b00010, 3'd0, RB};
    tbl[25] = '{W1, 5'b01010, 3'd0, RB};
    tbl[26] = '{W1, 5'b10010, 3'd0, RB};
    tbl[27] = '{W1, 5'b00010, 3'd0, RB};
    tbl[28] = '{W1, 5'b01010, 3'd0, RB};
    tbl[29] = '{W1, 5'b00110, 3'd0, RB};
    tbl[30] = '{W1, 5'b00010, 3'd0, RB};
    tbl[31] = '{W1, 5'b00000, 3'd0, RB};
    tbl[32] = '{W1, 5'b00000, 3'd0, RB};
    tbl[33] = '{W1, 5'b00000, 3'd0, RB};
    tbl[34] = '{W1, 5'b00000, 3'd0, RB};
    tbl[35] = '{W1, 5'b00010, 3'd0, RB};

    rst = 1'b0; en = 1'b0; fb_word = W0;
    exp_row_lat = 1'b0; exp_sel = 1'b0; rgb_chk = 1'b0;
`ifdef MATRIX_DBUF_EN
    swap_req = 1'b0;
`endif
    #12;
    reset_checks("por");

    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;

    // First scan row: cycle-exact table of planes 0 and 1
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      fb_word = tbl[i].word;
`ifdef MATRIX_DBUF_EN
      if (i == 10) swap_req = 1'b1;
`endif
      #1;
      chk("tbl_ctl", 32'({fb_rd, mat_clk, mat_lat, mat_oe, frame_start}), 32'(tbl[i].ctl));
      chk("tbl_addr", 32'(tbl[i].ctl[4] ? fb_addr[2:0] : 3'd0), 32'(tbl[i].addr));
      chk("tbl_rgb", 32'({mat_r, mat_g, mat_b}), 32'(tbl[i].rgb));
      chk("tbl_row", 32'(mat_row), 32'd0);
    end

    // Free-run through two more frame boundaries; drop en in row-0 plane-1 DISPLAY
    fb_word = WF;
    rgb_chk = 1'b1;
    for (int c = 36; c < 180; c++) begin
      @(negedge clk);
      if (c == 175) en = 1'b0;
      #1;
      check_model(c);
    end

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("idle_ctl", 32'({fb_rd, mat_clk, mat_lat, mat_oe, frame_start}), 32'(5'b00010));
      chk("idle_row", 32'(mat_row), 32'(exp_row_lat));
      if (k == 7) en = 1'b1;
    end

    // Restart from row 0 plane 0, then async reset during row-1 DISPLAY
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      #1;
      check_model(c);
    end
    rst = 1'b0;
    #1;
    reset_checks("async");
    exp_row_lat = 1'b0;
    exp_sel     = 1'b0;
    @(negedge clk);
    #1;
    reset_checks("hold");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      #1;
      check_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
